// File: rtl/cam_pkg.sv
// cam_pkg: shared types and defaults for the camera pixel assembler.
package cam_pkg;

    localparam int H_ACTIVE_DEF = 320;
    localparam int V_ACTIVE_DEF = 240;
    localparam int HC_W = 11;
    localparam int VC_W = 10;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        HIGH_BYTE,
        LOW_BYTE
    } cam_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-stage synchronizer with a one-cycle history copy for edge detection.
module sync_edge #(
    parameter int WIDTH = 11,
    parameter int STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] dly_out
);

    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
            dly_out <= '0;
        end else begin
            pipe[0] <= d_in;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
            dly_out <= pipe[STAGES-1];
        end
    end

    assign sync_out = pipe[STAGES-1];

endmodule

// File: rtl/camera_pixel_assembler.sv
// camera_pixel_assembler: turns the asynchronous 8-bit camera bus into RGB565 pixels with coordinates.
module camera_pixel_assembler
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            cam_pclk_in,
    input  logic            cam_vsync_in,
    input  logic            cam_href_in,
    input  logic [7:0]      cam_data_in,
    output logic [15:0]     pixel_out,
    output logic [HC_W-1:0] hcount_out,
    output logic [VC_W-1:0] vcount_out,
    output logic            data_valid_out,
    output logic            frame_done_out
);

    localparam logic [HC_W-1:0] H_LIM = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0] V_LIM = VC_W'(V_ACTIVE);
    localparam logic [HC_W-1:0] H_MAX = '1;
    localparam logic [VC_W-1:0] V_MAX = '1;

    logic [10:0] sync_bus, dly_bus;
    logic        ps, vs, hs, ps_d, vs_d, hs_d;
    logic [7:0]  ds, ds_d_unused;

    sync_edge #(.WIDTH(11), .STAGES(SYNC_STAGES)) u_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     ({cam_pclk_in, cam_vsync_in, cam_href_in, cam_data_in}),
        .sync_out (sync_bus),
        .dly_out  (dly_bus)
    );

    assign {ps, vs, hs, ds} = sync_bus;
    assign {ps_d, vs_d, hs_d, ds_d_unused} = dly_bus;

    logic pclk_rise, vs_fall, vs_rise, hs_fall, sample;

    assign pclk_rise = ps & ~ps_d;
    assign vs_fall   = ~vs & vs_d;
    assign vs_rise   = vs & ~vs_d;
    assign hs_fall   = ~hs & hs_d;
    assign sample    = pclk_rise & hs & ~vs;

    cam_state_t      state, state_n;
    logic [HC_W-1:0] h, h_n, hc_n;
    logic [VC_W-1:0] v, v_n, vc_n;
    logic [7:0]      hi, hi_n;
    rgb565_t         pix_n;
    logic            dv_n, fd_n;

    always_comb begin
        state_n = state;
        h_n     = h;
        v_n     = v;
        hi_n    = hi;
        pix_n   = pixel_out;
        hc_n    = hcount_out;
        vc_n    = vcount_out;
        dv_n    = 1'b0;
        fd_n    = 1'b0;
        if (state == WAIT_FRAME) begin
            if (vs_fall) begin
                h_n     = '0;
                v_n     = '0;
                state_n = HIGH_BYTE;
            end
        end else if (vs_rise) begin
            fd_n    = 1'b1;
            state_n = WAIT_FRAME;
        end else if (hs_fall) begin
            // an empty line leaves the row counter alone; a dangling high byte is simply forgotten
            v_n     = (h != '0 && v != V_MAX) ? v + 1'b1 : v;
            h_n     = '0;
            state_n = HIGH_BYTE;
        end else if (sample) begin
            if (state == HIGH_BYTE) begin
                hi_n    = ds;
                state_n = LOW_BYTE;
            end else begin
                state_n = HIGH_BYTE;
                h_n     = (h != H_MAX) ? h + 1'b1 : h;
                if (h < H_LIM && v < V_LIM) begin
                    pix_n = {hi, ds};
                    hc_n  = h;
                    vc_n  = v;
                    dv_n  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state          <= WAIT_FRAME;
            h              <= '0;
            v              <= '0;
            hi             <= '0;
            pixel_out      <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            data_valid_out <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            state          <= state_n;
            h              <= h_n;
            v              <= v_n;
            hi             <= hi_n;
            pixel_out      <= pix_n;
            hcount_out     <= hc_n;
            vcount_out     <= vc_n;
            data_valid_out <= dv_n;
            frame_done_out <= fd_n;
        end
    end

endmodule

// File: tb/tb_camera_pixel_assembler.sv
// tb_camera_pixel_assembler: drives a camera-bus model and checks pixels against a frame-level reference.
module tb_camera_pixel_assembler;

    localparam int H = 16;
    localparam int V = 6;

    logic        clk_in = 1'b0;
    logic        rst_n_in, cam_pclk_in, cam_vsync_in, cam_href_in;
    logic [7:0]  cam_data_in;
    logic [15:0] pixel_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        data_valid_out, frame_done_out;

    camera_pixel_assembler #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(2)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .cam_pclk_in    (cam_pclk_in),
        .cam_vsync_in   (cam_vsync_in),
        .cam_href_in    (cam_href_in),
        .cam_data_in    (cam_data_in),
        .pixel_out      (pixel_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .data_valid_out (data_valid_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    logic [36:0] got_q[$];
    int          fd_cnt = 0;
    int          wide_cnt = 0;
    logic        dv_prev = 1'b0, fd_prev = 1'b0;

    always @(negedge clk_in) begin
        if (data_valid_out) got_q.push_back({pixel_out, hcount_out, vcount_out});
        if (frame_done_out) fd_cnt++;
        if ((data_valid_out && dv_prev) || (frame_done_out && fd_prev)) wide_cnt++;
        dv_prev = data_valid_out;
        fd_prev = frame_done_out;
    end

    int          pass_cnt = 0, chk_cnt = 0;
    logic [36:0] exp_q[$];
    logic [7:0]  line_buf [64];
    int          model_v;
    int          base;

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic cam_byte(input logic [7:0] b);
        cam_data_in = b;
        cam_pclk_in = 1'b0;
        wclk(2);
        cam_pclk_in = 1'b1;
        wclk(2);
    endtask

    task automatic send_bytes(input int start, input int n);
        for (int i = 0; i < n; i++) cam_byte(line_buf[start+i]);
    endtask

    // reference: a line of n captured bytes yields n/2 pixels, clipped to the active window
    task automatic model_line(input int n);
        int npix;
        npix = n / 2;
        for (int p = 0; p < npix; p++)
            if (p < H && model_v < V)
                exp_q.push_back({line_buf[2*p], line_buf[2*p+1], 11'(p), 10'(model_v)});
        if (npix > 0) model_v++;
    endtask

    task automatic send_line(input int n, input bit capture);
        cam_href_in = 1'b1;
        wclk(2);
        send_bytes(0, n);
        cam_href_in = 1'b0;
        wclk(6);
        if (capture) model_line(n);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) line_buf[i] = 8'($urandom);
    endtask

    task automatic frame_begin();
        cam_vsync_in = 1'b0;
        wclk(4);
        model_v = 0;
    endtask

    task automatic frame_end();
        cam_vsync_in = 1'b1;
        wclk(8);
    endtask

    task automatic check_frame(input string name);
        int n, mism;
        n = got_q.size() - base;
        check({name, "_count"}, n, exp_q.size());
        mism = 0;
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (got_q[base+i] !== exp_q[i]) mism++;
        check({name, "_mismatches"}, mism, 0);
        base = got_q.size();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0]  b0, b1;
        logic [15:0] px;
        int          h, v;
    } vec_t;

    vec_t vt [8];

    initial begin
        int fd0, n, lines;
        logic [36:0] e;
        vt[0] = '{8'h12, 8'h34, 16'h1234, 0, 0};
        vt[1] = '{8'h56, 8'h78, 16'h5678, 1, 0};
        vt[2] = '{8'h9A, 8'hBC, 16'h9ABC, 2, 0};
        vt[3] = '{8'hDE, 8'hF0, 16'hDEF0, 3, 0};
        vt[4] = '{8'h13, 8'h57, 16'h1357, 0, 1};
        vt[5] = '{8'h9B, 8'hDF, 16'h9BDF, 1, 1};
        vt[6] = '{8'h24, 8'h68, 16'h2468, 2, 1};
        vt[7] = '{8'hAC, 8'hE0, 16'hACE0, 3, 1};
        base = 0;
        model_v = 0;
        rst_n_in = 1'b0;
        cam_pclk_in = 1'b1;
        cam_vsync_in = 1'b1;
        cam_href_in = 1'b0;
        cam_data_in = 8'h00;
        wclk(3);
        check("rst_pixel", pixel_out, 0);
        check("rst_hcount", hcount_out, 0);
        check("rst_vcount", vcount_out, 0);
        check("rst_valid", data_valid_out, 0);
        check("rst_done", frame_done_out, 0);
        rst_n_in = 1'b1;
        wclk(4);

        // href active under vsync before any vs_fall
        fill_random(8);
        send_line(8, 1'b0);
        frame_begin();
        wclk(4);
        check("prevsync_strobes", got_q.size(), 0);
        check("prevsync_done", fd_cnt, 0);
        frame_end();

        // table: 2 lines x 4 pixels
        fd0 = fd_cnt;
        frame_begin();
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 4; p++) begin
                line_buf[2*p]   = vt[4*l+p].b0;
                line_buf[2*p+1] = vt[4*l+p].b1;
            end
            send_line(8, 1'b0);
        end
        frame_end();
        check("table_count", got_q.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            e = (base + i < got_q.size()) ? got_q[base+i] : 37'h0;
            check($sformatf("table%0d_pixel", i), e[36:21], vt[i].px);
            check($sformatf("table%0d_hcount", i), e[20:10], vt[i].h);
            check($sformatf("table%0d_vcount", i), e[9:0], vt[i].v);
        end
        base = got_q.size();
        check("table_frame_done", fd_cnt - fd0, 1);
        check("hold_pixel", pixel_out, 16'hACE0);
        check("hold_hcount", hcount_out, 3);
        check("hold_vcount", vcount_out, 1);

        // oversized frame: clipped to H x V
        fd0 = fd_cnt;
        frame_begin();
        for (int l = 0; l < V + 1; l++) begin
            fill_random(2 * (H + 10));
            send_line(2 * (H + 10), 1'b1);
        end
        frame_end();
        e = (got_q.size() > 0) ? got_q[got_q.size()-1] : 37'h0;
        check("full_last_hcount", e[20:10], H - 1);
        check("full_last_vcount", e[9:0], V - 1);
        check_frame("full");
        check("full_frame_done", fd_cnt - fd0, 1);

        // odd byte count: trailing byte dropped, next line re-pairs from h=0
        frame_begin();
        fill_random(9);
        send_line(9, 1'b1);
        fill_random(8);
        send_line(8, 1'b1);
        frame_end();
        check_frame("odd");

        // href falling together with a pclk rise drops that byte
        frame_begin();
        fill_random(8);
        cam_href_in = 1'b1;
        wclk(2);
        send_bytes(0, 7);
        cam_data_in = line_buf[7];
        cam_pclk_in = 1'b0;
        wclk(2);
        cam_pclk_in = 1'b1;
        cam_href_in = 1'b0;
        wclk(6);
        model_line(7);
        fill_random(4);
        send_line(4, 1'b1);
        frame_end();
        check_frame("coincident");

        // reset mid-line 5 after pixel 10
        fd0 = fd_cnt;
        frame_begin();
        for (int l = 0; l < 5; l++) begin
            fill_random(12);
            send_line(12, 1'b1);
        end
        fill_random(32);
        cam_href_in = 1'b1;
        wclk(2);
        send_bytes(0, 20);
        wclk(4);
        model_line(20);
        check_frame("prereset");
        rst_n_in = 1'b0;
        wclk(1);
        check("midrst_pixel", pixel_out, 0);
        check("midrst_hcount", hcount_out, 0);
        check("midrst_vcount", vcount_out, 0);
        check("midrst_valid", data_valid_out, 0);
        check("midrst_done", frame_done_out, 0);
        rst_n_in = 1'b1;
        send_bytes(20, 12);
        cam_href_in = 1'b0;
        wclk(6);
        fill_random(12);
        send_line(12, 1'b0);
        frame_end();
        check("postrst_strobes", got_q.size() - base, 0);
        check("postrst_done", fd_cnt - fd0, 0);
        frame_begin();
        fill_random(8);
        send_line(8, 1'b1);
        frame_end();
        e = (got_q.size() > base) ? got_q[base] : '1;
        check("postrst_first_h", e[20:10], 0);
        check("postrst_first_v", e[9:0], 0);
        check_frame("postrst");

        // randomized frames against the reference
        for (int f = 0; f < 4; f++) begin
            fd0 = fd_cnt;
            frame_begin();
            lines = $urandom_range(1, V + 2);
            for (int l = 0; l < lines; l++) begin
                n = $urandom_range(0, 2 * H + 6);
                fill_random(n);
                send_line(n, 1'b1);
            end
            frame_end();
            check_frame($sformatf("rand%0d", f));
            check($sformatf("rand%0d_done", f), fd_cnt - fd0, 1);
        end

        check("pulse_width", wide_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
